// File: rtl/demosaic_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : demosaic_mul_arbiter
// Purpose  : Shares one unsigned A_WIDTH x B_WIDTH multiplier between NUM_REQ
//            requesters (the R/G/B gain-scaling paths of the demosaic core).
//            Requests are granted round-robin, the operands and the product
//            are registered in a 2-stage pipeline, and each product returns on
//            a single response channel tagged with the requester index.
// Ports    : ap_clk     - clock, rising edge
//            ap_rst_n   - asynchronous active-low reset
//            req_valid  - per-requester request valid
//            req_ready  - per-requester accept (one-hot or zero)
//            req_a      - packed operand A, requester i at [i*A_WIDTH +: A_WIDTH]
//            req_b      - packed operand B, same packing
//            rsp_valid  - response valid
//            rsp_ready  - downstream accept
//            rsp_p      - (a*b) mod 2^P_WIDTH
//            rsp_id     - index of the requester that issued the product
//            busy       - either pipeline stage holds valid data
// Revision : 1.0 - initial release
// ============================================================================
module demosaic_mul_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ID_WIDTH = 2,
    parameter int A_WIDTH  = 20,
    parameter int B_WIDTH  = 8,
    parameter int P_WIDTH  = 27
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [P_WIDTH-1:0]           rsp_p,
    output logic [ID_WIDTH-1:0]          rsp_id,
    output logic                         busy
);

    // Requester slots are padded to a power of two so a grant index of
    // exactly ID_WIDTH bits can address them without width adaptation.
    localparam int                  c_slots   = 1 << ID_WIDTH;
    localparam int                  c_prod_w  = A_WIDTH + B_WIDTH;
    localparam logic [ID_WIDTH:0]   c_num_req = (ID_WIDTH+1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] c_ptr_rst = ID_WIDTH'(NUM_REQ - 1);

    // Operand stage
    logic                r_s1_valid;
    logic [A_WIDTH-1:0]  r_s1_a;
    logic [B_WIDTH-1:0]  r_s1_b;
    logic [ID_WIDTH-1:0] r_s1_id;
    // Product stage
    logic                r_s2_valid;
    logic [P_WIDTH-1:0]  r_s2_p;
    logic [ID_WIDTH-1:0] r_s2_id;
    // Last granted requester
    logic [ID_WIDTH-1:0] r_rr_ptr;

    logic [c_slots-1:0]  w_valid_pad;
    logic [A_WIDTH-1:0]  w_a_arr [c_slots];
    logic [B_WIDTH-1:0]  w_b_arr [c_slots];
    logic                w_adv1;
    logic                w_adv2;
    logic                w_found;
    logic [ID_WIDTH-1:0] w_grant;
    logic [ID_WIDTH:0]   w_cand;
    logic                w_xfer;
    logic [P_WIDTH-1:0]  w_prod;

    // ------------------------------------------------------------------
    // Unpack the request bus into per-slot views; unused slots read 0.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < c_slots; i++) begin : g_slot
            if (i < NUM_REQ) begin : g_used
                assign w_valid_pad[i] = req_valid[i];
                assign w_a_arr[i]     = req_a[i*A_WIDTH +: A_WIDTH];
                assign w_b_arr[i]     = req_b[i*B_WIDTH +: B_WIDTH];
            end else begin : g_unused
                assign w_valid_pad[i] = 1'b0;
                assign w_a_arr[i]     = '0;
                assign w_b_arr[i]     = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Flow control: a stage may take new data when it is empty or when the
    // stage after it is emptying this cycle.
    // ------------------------------------------------------------------
    assign w_adv2 = !r_s2_valid || rsp_ready;
    assign w_adv1 = !r_s1_valid || w_adv2;

    // ------------------------------------------------------------------
    // Round-robin search starting just after the last granted requester.
    // The candidate index is kept one bit wider so the wrap is a single
    // conditional subtract (pointer + offset never exceeds 2*NUM_REQ-1).
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(k);
            if (w_cand >= c_num_req) begin
                w_cand = w_cand - c_num_req;
            end
            if (!w_found && w_valid_pad[w_cand[ID_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_cand[ID_WIDTH-1:0];
            end
        end
    end

    assign w_xfer = w_found && w_adv1;

    // Ready is held low while reset is asserted, even if a requester is
    // already presenting valid.
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
            assign req_ready[i] = ap_rst_n && w_xfer && (w_grant == ID_WIDTH'(i));
        end
    endgenerate

    // Operands are widened to the full product width before multiplying so
    // no product bit is lost ahead of the deliberate truncation.
    assign w_prod = P_WIDTH'(c_prod_w'(r_s1_a) * c_prod_w'(r_s1_b));

    // ------------------------------------------------------------------
    // Pipeline registers and arbitration pointer
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_p     <= '0;
            r_s2_id    <= '0;
            r_rr_ptr   <= c_ptr_rst;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= w_xfer;
                if (w_xfer) begin
                    r_s1_a  <= w_a_arr[w_grant];
                    r_s1_b  <= w_b_arr[w_grant];
                    r_s1_id <= w_grant;
                end
            end
            // The pointer only moves on an accepted transfer so an idle
            // cycle does not disturb the rotation.
            if (w_xfer) begin
                r_rr_ptr <= w_grant;
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_p  <= w_prod;
                    r_s2_id <= r_s1_id;
                end
            end
        end
    end

    assign rsp_valid = r_s2_valid;
    assign rsp_p     = r_s2_p;
    assign rsp_id    = r_s2_id;
    assign busy      = r_s1_valid || r_s2_valid;

endmodule
`default_nettype wire

// File: doc/demosaic_mul_arbiter.md
Name: demosaic_mul_arbiter

Overview:
- Shares one unsigned 20x8 multiplier between NUM_REQ requesters. In the demosaic core these are the R/G/B gain-scaling paths, which previously each owned a multiplier instance.
- Round-robin arbitrates valid/ready requests and registers the operands and the product in a 2-stage pipeline.
- Returns each product on a single response channel, tagged with the requester index.
- Sits between the per-channel interpolation stages and the output packer.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- ID_WIDTH, 2, width of the requester tag; must satisfy 2^ID_WIDTH >= NUM_REQ.
- A_WIDTH, 20, operand A width, unsigned.
- B_WIDTH, 8, operand B width, unsigned.
- P_WIDTH, 27, product width; product is truncated to the low P_WIDTH bits.

Ports:
- ap_clk  in  1  clock; all logic is rising-edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; a transfer occurs when bit i of both valid and ready is 1.
- req_a  in  NUM_REQ*A_WIDTH  operand A, packed; requester i occupies bits [i*A_WIDTH +: A_WIDTH].
- req_b  in  NUM_REQ*B_WIDTH  operand B, packed the same way.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accept.
- rsp_p  out  P_WIDTH  product: (a*b) mod 2^P_WIDTH.
- rsp_id  out  ID_WIDTH  index of the requester that issued the product.
- busy  out  1  high when either pipeline stage holds valid data.

Behaviour:

Pipeline stages:
- S1 (operand register): s1_valid, s1_a, s1_b, s1_id.
- S2 (product register): s2_valid, s2_p, s2_id.
- rsp_valid = s2_valid, rsp_p = s2_p, rsp_id = s2_id, all driven directly from registers.

Reset (ap_rst_n low, asynchronous):
- s1_valid = 0, s2_valid = 0.
- s1_a, s1_b, s1_id, s2_p, s2_id all cleared to 0.
- rr_ptr = NUM_REQ-1, so requester 0 has first priority after reset.
- Outputs during reset: rsp_valid = 0, rsp_p = 0, rsp_id = 0, busy = 0, req_ready = 0.
- Reset asserted mid-operation discards all in-flight data; no response is produced for it.

Flow control:
- adv2 = !s2_valid | rsp_ready.
- adv1 = !s1_valid | adv2.
- Stages advance only when their adv term is true; otherwise they hold their contents unchanged.
- When rsp_valid=1 and rsp_ready=0, rsp_p and rsp_id must remain stable until accepted.

Arbitration (combinational):
- Search req_valid in round-robin order starting at (rr_ptr+1) mod NUM_REQ; the first set bit is the grant g.
- req_ready is one-hot or zero: req_ready[g] = adv1, all other bits 0.
- req_ready depends on req_valid. Requesters must not make valid depend on ready.
- Requesters must hold valid and operands stable until accepted.

On an accepted transfer:
- S1 loads a[g], b[g] and id = g.
- rr_ptr <= g.
- With no accept, rr_ptr is unchanged; it updates only on accepted transfers.

Arithmetic and S2 load:
- When adv2 and s1_valid: s2_p <= low P_WIDTH bits of the full (A_WIDTH+B_WIDTH)-bit unsigned product s1_a*s1_b; s2_id <= s1_id.
- s2_valid <= s1_valid whenever adv2.
- s1_valid <= (transfer occurred) whenever adv1.

Latency and throughput:
- A request accepted at edge T appears on rsp at T+1 and is visible for the cycle after T+1. This is 2 register stages with no stall.
- Throughput is 1 product per cycle.
- Responses leave in acceptance order.

Fairness:
- With all requesters continuously valid and no stall, grants rotate 0,1,2,0,1,2...
- No requester waits more than NUM_REQ-1 accepted transfers.

Boundary conditions:
- Simultaneous S2 drain (rsp_ready) and S1 refill in the same cycle is permitted.
- With S2 full and not drained while S1 is full: req_ready = 0 for every requester.
- Operand values of 0 are legal and produce rsp_p = 0.
- busy = s1_valid | s2_valid.

Test Plan:
- Reset then idle: rsp_valid=0, all req_ready=0, busy=0. Assert req_valid[0] with a=1000, b=3 at cycle 0 -> accepted on cycle 0; rsp_valid=1, rsp_p=3000, rsp_id=0 after 2 edges.
- All 3 requesters continuously valid (a=i+1, b=10), rsp_ready=1 -> accepted ids 0,1,2,0,1,2; rsp_p 10,20,30,... one per cycle, no bubbles.
- Truncation: a=0xFFFFF, b=0xFF -> full product 0xFEFFF01; rsp_p=0x7EFFF01. Also a=0, b=0xFF -> rsp_p=0.
- Backpressure: rsp_ready=0 for 5 cycles with requests pending -> exactly 2 requests accepted, then req_ready=0. rsp_p/rsp_id stay stable. Release rsp_ready -> no loss or duplication, order preserved.
- Fairness after idle: only requester 2 accepted, then 0 and 2 both valid -> requester 0 granted next.
- Async reset asserted mid-stream with both stages full -> rsp_valid and busy drop immediately, without a clock edge. After release, the first grant goes to requester 0 and no stale response appears.
